// File: rtl/display_counter_scheduler.sv
// Run/pause/step hex counter with a multiplexed 4-digit 7-segment scanner.
// Optional leading-zero blanking: define DISPLAY_LEADING_ZERO_BLANK_EN.
module display_counter_scheduler #(
   parameter int unsigned SCAN_DIV = 4
) (
   input  logic       input_clock1_1,
   input  logic       input_reset1_2,
   input  logic       input_run_button_3,
   input  logic       input_step_button_4,
   input  logic       input_clear_5,
   input  logic       input_tick_6,
   output logic [6:0] output_segments_7,
   output logic [3:0] output_digit_select_8,
   output logic       output_dp_dot_9,
   output logic       output_running_10
);

   localparam int unsigned COUNT_DIGITS = 4;
   localparam int unsigned CW           = 4 * COUNT_DIGITS;

   typedef enum logic {
      ST_PAUSED,
      ST_RUNNING
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic            r_run_q;
   logic            r_step_q;
   logic            w_run_rise;
   logic            w_step_rise;
   logic            w_inc;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_count_next;
   logic [7:0]      r_presc;
   logic [1:0]      r_idx;
   logic            w_presc_wrap;
   logic [3:0]      w_nibble;
   logic [6:0]      w_seg_dec;
   logic [6:0]      w_seg;
   logic            w_blank;

   assign w_run_rise   = input_run_button_3 & ~r_run_q;
   assign w_step_rise  = input_step_button_4 & ~r_step_q;
   assign w_presc_wrap = (r_presc == 8'(SCAN_DIV - 1));

   // Increment decision uses the pre-toggle state; a run edge only changes the next state.
   always_comb begin
      w_state_next = r_state;
      w_inc        = 1'b0;
      case (r_state)
         ST_PAUSED: begin
            w_inc = w_step_rise;
            if (w_run_rise) w_state_next = ST_RUNNING;
         end
         ST_RUNNING: begin
            w_inc = input_tick_6;
            if (w_run_rise) w_state_next = ST_PAUSED;
         end
         default: w_state_next = ST_PAUSED;
      endcase
   end

   always_comb begin
      w_count_next = r_count;
      if (input_clear_5)
         w_count_next = '0;
      else if (w_inc)
         w_count_next = r_count + 1'b1;
   end

   assign w_nibble = r_count[{r_idx, 2'b00} +: 4];

   always_comb begin
      w_seg_dec = 7'h00;
      case (w_nibble)
         4'h0: w_seg_dec = 7'h3F;
         4'h1: w_seg_dec = 7'h06;
         4'h2: w_seg_dec = 7'h5B;
         4'h3: w_seg_dec = 7'h4F;
         4'h4: w_seg_dec = 7'h66;
         4'h5: w_seg_dec = 7'h6D;
         4'h6: w_seg_dec = 7'h7D;
         4'h7: w_seg_dec = 7'h07;
         4'h8: w_seg_dec = 7'h7F;
         4'h9: w_seg_dec = 7'h6F;
         4'hA: w_seg_dec = 7'h77;
         4'hB: w_seg_dec = 7'h7C;
         4'hC: w_seg_dec = 7'h39;
         4'hD: w_seg_dec = 7'h5E;
         4'hE: w_seg_dec = 7'h79;
         4'hF: w_seg_dec = 7'h71;
         default: w_seg_dec = 7'h00;
      endcase
   end

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
   logic [1:0] w_lead;

   // Highest nonzero nibble; digit 0 is the floor so zero still shows one digit.
   always_comb begin
      w_lead = 2'd0;
      if (r_count[15:12] != 4'h0)
         w_lead = 2'd3;
      else if (r_count[11:8] != 4'h0)
         w_lead = 2'd2;
      else if (r_count[7:4] != 4'h0)
         w_lead = 2'd1;
   end

   assign w_blank = (r_idx > w_lead);
`else
   assign w_blank = 1'b0;
`endif

   assign w_seg = w_blank ? 7'h00 : w_seg_dec;

   always_ff @(posedge input_clock1_1) begin
      if (input_reset1_2) begin
         r_state               <= ST_PAUSED;
         r_run_q               <= input_run_button_3;
         r_step_q              <= input_step_button_4;
         r_count               <= '0;
         r_presc               <= '0;
         r_idx                 <= '0;
         output_segments_7     <= 7'h3F;
         output_digit_select_8 <= 4'b0001;
         output_dp_dot_9       <= 1'b0;
      end else begin
         r_state               <= w_state_next;
         r_run_q               <= input_run_button_3;
         r_step_q              <= input_step_button_4;
         r_count               <= w_count_next;
         r_presc               <= w_presc_wrap ? '0 : r_presc + 1'b1;
         if (w_presc_wrap) r_idx <= r_idx + 1'b1;
         output_segments_7     <= w_seg;
         output_digit_select_8 <= 4'b0001 << r_idx;
         output_dp_dot_9       <= (r_idx == 2'd0) && (r_state == ST_RUNNING);
      end
   end

   assign output_running_10 = (r_state == ST_RUNNING);

endmodule

// File: doc/display_counter_scheduler.md
DISPLAY_COUNTER_SCHEDULER -- requirements
Module: display_counter_scheduler

Interface
REQ-001 Parameter SCAN_DIV, default 4, clock cycles each digit stays selected before the scanner advances (legal range 2..255).
REQ-002 Parameter COUNT_DIGITS, fixed 4, number of hex digits in the counter and the display; not overridable.
REQ-003 input_clock1_1  in  1  single clock; all state updates on its rising edge.
REQ-004 input_reset1_2  in  1  reset, synchronous, active-high.
REQ-005 input_run_button_3  in  1  run/pause push button, level; a rising edge toggles the run state.
REQ-006 input_step_button_4  in  1  single-step push button, level; a rising edge while paused increments once.
REQ-007 input_clear_5  in  1  level; while high, the counter is held at 0x0000.
REQ-008 input_tick_6  in  1  one-cycle count strobe; increments while running.
REQ-009 output_segments_7  out  7  segment drive {g,f,e,d,c,b,a}, active-high, registered.
REQ-010 output_digit_select_8  out  4  one-hot digit enable, active-high, registered; bit n selects digit n (digit 0 least significant).
REQ-011 output_dp_dot_9  out  1  decimal point, registered.
REQ-012 output_running_10  out  1  high in RUNNING state.

Function
REQ-013 FSM: two states. PAUSED goes to RUNNING on a run rising edge; RUNNING goes to PAUSED on a run rising edge; otherwise the state holds.
REQ-014 Edge detection: each button is registered once; rising edge = current high AND previous-sample low; no debounce inside the block.
REQ-015 Increment conditions: the counter adds 1 when (RUNNING and input_tick_6) or (PAUSED and step rising edge); otherwise it holds.
REQ-016 Same-cycle run edge and tick: the increment decision uses the state before the toggle (current state); the toggle takes effect the next cycle.
REQ-017 Same-cycle step edge and run edge while PAUSED: the step increments, the state becomes RUNNING, and no further step action occurs.
REQ-018 Step edge in RUNNING: ignored.
REQ-019 Counter: 16-bit unsigned (4 hex digits); 0xFFFF + 1 wraps to 0x0000; no carry output.
REQ-020 Clear: input_clear_5 forces the counter to 0x0000 next cycle with priority over increment; the FSM and scanner are unaffected.
REQ-021 Scanner prescaler: counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and the digit index advances 0,1,2,3,0 (wraps after 3).
REQ-022 Digit output: output_digit_select_8 = 1 << index.
REQ-023 Segment output: output_segments_7 = hex decode of counter nibble[index].
REQ-024 Segment and digit-select timing: both register in the same cycle from the same index, so they are always mutually consistent.
REQ-025 Segment latency: output_segments_7 reflects the counter value one cycle after that value is updated.
REQ-026 Hex decode table {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71.
REQ-027 Decimal point: output_dp_dot_9 is high only when index = 0 and the state is RUNNING.
REQ-028 output_running_10: equals (state == RUNNING), registered.

Reset
REQ-029 While input_reset1_2 is high at a clock edge, the block loads: state PAUSED; counter 0x0000; prescaler 0; index 0; output_digit_select_8 = 4'b0001; output_segments_7 = 7'h3F; output_dp_dot_9 = 0; output_running_10 = 0.
REQ-030 During reset, the button sample registers load the current button levels, so a button held through reset release produces no edge.
REQ-031 Reset asserted mid-count or mid-scan overrides all other inputs in that cycle; there is no partial-update state.
REQ-032 Behaviour before the first reset is undefined; the bench shall assert reset for at least 2 cycles.

Configuration
REQ-033 Macro DISPLAY_LEADING_ZERO_BLANK_EN: when defined, a digit whose index is above the most-significant nonzero nibble drives segments 7'h00 (the decimal point is unaffected).
REQ-034 With DISPLAY_LEADING_ZERO_BLANK_EN, digit 0 is never blanked, so 0x0000 shows a single "0".
REQ-035 With DISPLAY_LEADING_ZERO_BLANK_EN undefined, all four digits always display their decoded value; the scan timing is identical in both builds.

Verification
REQ-036 Reset, then 4*SCAN_DIV cycles idle -> digit_select sequence 0001,0010,0100,1000 each held 4 cycles; segments 3F throughout; running 0.
REQ-037 Run edge, then 20 tick strobes -> running 1; counter 0x0014; digit0 segments 66; digit1 segments 06; dp high only on digit0.
REQ-038 Paused, 3 step edges plus 5 ticks -> counter 0x0003; step edges while running -> no change.
REQ-039 Counter preset via ticks to 0xFFFF, one more tick -> 0x0000; simultaneous clear and tick -> 0x0000.
REQ-040 Run held high across reset release -> no toggle, running stays 0; run edge plus tick in the same cycle while PAUSED -> no increment, running 1 next cycle.
REQ-041 DISPLAY_LEADING_ZERO_BLANK_EN build, counter 0x0012 -> digits 3 and 2 segments 00; digit1 06; digit0 5B.
